// File: rtl/bi_set_counter_poller.sv
// bi_set_counter_poller
//   Sweeps read-to-clear accesses over NUM BiSet pulse counters located at
//   ADDR_BASE .. ADDR_BASE+NUM-1, and accumulates every returned 32-bit delta
//   into a per-counter saturating total of TOTAL_W bits. Sweeps start every
//   PERIOD cycles or on trig_i. Starts that are requested while a sweep is
//   running are held in a single pending flag.
//
// Ports
//   clk_i       clock
//   rst_i       synchronous active-high reset
//   setCtrl_o   BiSet request toward the counters (registered)
//   setReply_i  OR-combined reply of the counters
//   trig_i      request a sweep at the next IDLE cycle
//   clear_i     zero all totals
//   sel_i       total select for the read port
//   total_o     registered total of counter sel_i (0 when sel_i >= NUM)
//   busy_o      sweep in progress (REQ or CAPT)
//   done_o      one-cycle pulse in the final CAPT cycle of a sweep

package BiSet;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] data;
  } biSetCtrl;

  typedef struct packed {
    logic [DATA_W-1:0] data;
  } biSetReply;

  // Idle request: req low, so no register decodes it.
  localparam biSetCtrl BiSetCtrlIdle = '{req: 1'b0, addr: '0, we: 1'b0, data: '0};

  function automatic biSetCtrl BiSetCtrlPack(input logic [ADDR_W-1:0] addr,
                                             input logic              we,
                                             input logic [DATA_W-1:0] data);
    biSetCtrl c;
    c.req  = 1'b1;
    c.addr = addr;
    c.we   = we;
    c.data = data;
    return c;
  endfunction

  function automatic logic [DATA_W-1:0] BiSetReplyData(input biSetReply r);
    return r.data;
  endfunction

endpackage

module bi_set_counter_poller #(
  parameter int unsigned ADDR_BASE = 0,
  parameter int unsigned NUM       = 4,
  parameter int unsigned PERIOD    = 1024,
  parameter int unsigned TOTAL_W   = 64
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  output BiSet::biSetCtrl                      setCtrl_o,
  input  BiSet::biSetReply                     setReply_i,
  input  logic                                 trig_i,
  input  logic                                 clear_i,
  input  logic [((NUM > 1) ? $clog2(NUM) : 1)-1:0] sel_i,
  output logic [TOTAL_W-1:0]                   total_o,
  output logic                                 busy_o,
  output logic                                 done_o
);

  localparam int unsigned SEL_W = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int unsigned TMR_W = $clog2(PERIOD);
  localparam int unsigned AW    = BiSet::ADDR_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_CAPT = 2'd2;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [SEL_W-1:0]   idx;
  logic [SEL_W-1:0]   idx_nxt;
  logic [TMR_W-1:0]   timer;
  logic               pend;
  logic [TOTAL_W-1:0] total [NUM];

  logic               last;
  logic               period_hit;
  logic               start;
  logic [31:0]        delta;
  logic [TOTAL_W-1:0] total_sel;
  logic [TOTAL_W-1:0] total_cur;
  logic [TOTAL_W:0]   sum;
  logic [TOTAL_W-1:0] sum_sat;
  logic [AW-1:0]      rd_addr;

  assign delta      = BiSet::BiSetReplyData(setReply_i);
  assign last       = (idx == SEL_W'(NUM - 1));
  assign period_hit = (timer == TMR_W'(PERIOD - 1));
  assign start      = (state == S_IDLE) && (period_hit || trig_i || pend);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_REQ;
      S_REQ:   state_nxt = S_CAPT;
      S_CAPT:  state_nxt = last ? S_IDLE : S_REQ;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    idx_nxt = idx;
    if (state == S_CAPT) idx_nxt = last ? '0 : idx + 1'b1;
  end

  assign rd_addr = AW'(ADDR_BASE) + AW'(idx_nxt);

  // Mux-by-compare instead of array indexing keeps sel_i >= NUM reading 0
  // and tolerates non-power-of-two NUM without out-of-range indexing.
  always_comb begin
    total_sel = '0;
    total_cur = '0;
    for (int unsigned k = 0; k < NUM; k++) begin
      if (sel_i == SEL_W'(k)) total_sel = total[k];
      if (idx == SEL_W'(k))   total_cur = total[k];
    end
  end

  assign sum     = {1'b0, total_cur} + (TOTAL_W + 1)'(delta);
  assign sum_sat = sum[TOTAL_W] ? '1 : sum[TOTAL_W-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      idx       <= '0;
      timer     <= '0;
      pend      <= 1'b0;
      setCtrl_o <= BiSet::BiSetCtrlIdle;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      total_o   <= '0;
      for (int unsigned k = 0; k < NUM; k++) total[k] <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;

      // Free-running period timer, realigned whenever a sweep starts.
      if (start || period_hit) timer <= '0;
      else                     timer <= timer + 1'b1;

      if (start)
        pend <= 1'b0;
      else if ((state != S_IDLE) && (trig_i || period_hit))
        pend <= 1'b1;

      // Outputs are registered from the next state so they line up with
      // the state they describe: the read is on the bus during REQ, and
      // done_o marks the final CAPT.
      setCtrl_o <= (state_nxt == S_REQ) ? BiSet::BiSetCtrlPack(rd_addr, 1'b0, '0)
                                        : BiSet::BiSetCtrlIdle;
      busy_o    <= (state_nxt != S_IDLE);
      done_o    <= (state == S_REQ) && last;
      total_o   <= total_sel;

      for (int unsigned k = 0; k < NUM; k++) begin
        if (clear_i)
          total[k] <= '0;
        else if ((state == S_CAPT) && (idx == SEL_W'(k)))
          total[k] <= sum_sat;
      end
    end
  end

endmodule

// File: tb/tb_bi_set_counter_poller.sv
// Self-checking bench for bi_set_counter_poller (NUM=2, PERIOD=16,
// TOTAL_W=33). A per-cycle expectation of the bus/busy/done timing is
// derived from the list of sweep start cycles; totals are checked through a
// scoreboard fed by a reference model of the counters and accumulators.

module tb_bi_set_counter_poller;

  localparam int unsigned ADDR_BASE = 32;
  localparam int unsigned NUM       = 2;
  localparam int unsigned PERIOD    = 16;
  localparam int unsigned TOTAL_W   = 33;
  localparam logic [63:0] MAXT      = 64'h1_FFFF_FFFF;
  localparam int          NSW       = 10;

  logic                 clk;
  logic                 rst_i;
  BiSet::biSetCtrl      set_ctrl;
  BiSet::biSetReply     set_reply;
  logic                 trig_i;
  logic                 clear_i;
  logic [0:0]           sel_i;
  logic [TOTAL_W-1:0]   total_o;
  logic                 busy_o;
  logic                 done_o;

  bi_set_counter_poller #(
    .ADDR_BASE(ADDR_BASE),
    .NUM      (NUM),
    .PERIOD   (PERIOD),
    .TOTAL_W  (TOTAL_W)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .setCtrl_o (set_ctrl),
    .setReply_i(set_reply),
    .trig_i    (trig_i),
    .clear_i   (clear_i),
    .sel_i     (sel_i),
    .total_o   (total_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Sweep start cycles (cycle 0 = first cycle after reset release) and the
  // values the two counters return in each sweep.
  int          starts [NSW] = '{16, 32, 48, 64, 80, 96, 101, 117, 126, 142};
  logic [31:0] rep0   [NSW] = '{32'd5, 32'd7, 32'd1, 32'd2, 32'd9, 32'd4,
                                32'd10, 32'd0, 32'd3, 32'h11};
  logic [31:0] rep1   [NSW] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3, 32'd0, 32'd0,
                                32'd6, 32'd1, 32'd0, 32'd3, 32'h55};
  logic [31:0] rep_val [NUM];

  // Expected {req, busy, done, addr}; reset in cycle 144 aborts sweep 142.
  function automatic logic [63:0] exp_bus(input int c);
    logic          req  = 1'b0;
    logic          busy = 1'b0;
    logic          done = 1'b0;
    logic [15:0]   a    = '0;
    if (c < 145) begin
      for (int n = 0; n < NSW; n++) begin
        if (c >= starts[n] && c <= starts[n] + 3) begin
          busy = 1'b1;
          if (c == starts[n] + 3) done = 1'b1;
          if (c == starts[n] || c == starts[n] + 2) begin
            req = 1'b1;
            a   = 16'(ADDR_BASE + (c - starts[n]) / 2);
          end
        end
      end
    end
    return {45'b0, req, busy, done, a};
  endfunction

  typedef struct {
    int          k;
    logic [63:0] val;
    int          due;
  } sb_t;

  sb_t sb_q [$];

  // Counter/accumulator model: answers each observed read in the next
  // cycle and predicts total_o two cycles after that capture.
  initial begin
    logic [63:0] m [NUM];
    logic [63:0] nv;
    int          ncyc     = 0;
    logic        cap_pend = 1'b0;
    logic        cap_kill = 1'b0;
    int          cap_k    = 0;
    sb_t         e;
    m[0] = '0;
    m[1] = '0;
    set_reply = '0;
    sel_i     = '0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (sb_q.size() != 0 && sb_q[0].due == ncyc) begin
        e = sb_q.pop_front();
        check($sformatf("total%0d@%0d", e.k, ncyc), 64'(total_o), e.val);
      end
      set_reply = '0;
      if (cap_pend) begin
        set_reply.data = rep_val[cap_k];
        sel_i          = 1'(cap_k);
      end
      if (rst_i) begin
        m[0] = '0;
        m[1] = '0;
        sb_q.delete();
      end else if (clear_i) begin
        m[0] = '0;
        m[1] = '0;
      end else if (cap_pend && !cap_kill) begin
        nv = m[cap_k] + 64'(rep_val[cap_k]);
        m[cap_k] = (nv > MAXT) ? MAXT : nv;
      end
      if (cap_pend && !rst_i)
        sb_q.push_back('{k: cap_k, val: m[cap_k], due: ncyc + 2});
      cap_pend = 1'b0;
      if (set_ctrl.req === 1'b1) begin
        check($sformatf("rd_fmt@%0d", ncyc), 64'({set_ctrl.we, set_ctrl.data}), 64'd0);
        cap_k = int'(set_ctrl.addr) - int'(ADDR_BASE);
        if (cap_k >= 0 && cap_k < int'(NUM)) begin
          cap_pend = 1'b1;
          cap_kill = rst_i;
        end else begin
          check($sformatf("rd_range@%0d", ncyc), 64'(set_ctrl.addr), 64'(ADDR_BASE));
        end
      end
    end
  end

  initial begin
    logic [63:0] got;
    rst_i      = 1'b1;
    trig_i     = 1'b0;
    clear_i    = 1'b0;
    rep_val[0] = '0;
    rep_val[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl",  64'(set_ctrl), 64'(BiSet::BiSetCtrlIdle));
    check("rst_busy",  64'(busy_o),   64'd0);
    check("rst_done",  64'(done_o),   64'd0);
    check("rst_total", 64'(total_o),  64'd0);
    rst_i = 1'b0;

    for (int c = 0; c <= 150; c++) begin
      for (int n = 0; n < NSW; n++) begin
        if (c == starts[n]) begin
          rep_val[0] = rep0[n];
          rep_val[1] = rep1[n];
        end
      end
      clear_i = (c == 81);
      trig_i  = (c == 97) || (c == 100) || (c == 125);
      rst_i   = (c == 144);
      got = {45'b0, set_ctrl.req, busy_o, done_o, set_ctrl.req ? set_ctrl.addr : 16'h0};
      check($sformatf("bus@%0d", c), got, exp_bus(c));
      @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
